rope_engine: RTL and testbench

Parametrised successor to the static rope renderer for the tug-of-war display. It owns the rope position register, accumulates per-player pull pulses over each video frame, and applies one clamped move per frame tick. It runs a play/win state machine and emits a registered 2-bit icon code per pixel for the VGA colorizer. It sits between the debounced button/GPIO logic and the colorizer, on the pixel clock.

---
 rtl/rope_pkg.sv | 34 +++
 rtl/rope_pull_counter.sv | 47 ++++
 rtl/rope_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_rope_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rope_pkg.sv
`default_nettype none
// ============================================================================
// Module : rope_pkg
// Purpose: Shared game-state encodings, icon codes and position/arithmetic
//          widths for the tug-of-war rope engine.
// Rev    : 1.0  initial parametrised release
// ============================================================================
package rope_pkg;

  // Width of pixel rows/columns and the rope position register.
  localparam int POS_W   = 10;
  // Signed width used for position arithmetic; wide enough that a full-scale
  // move or band edge never wraps before clamping.
  localparam int ARITH_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_WIN_TOP = 2'd2,
    ST_WIN_BOT = 2'd3
  } state_e;

  localparam logic [1:0] ICON_BG    = 2'b00;
  localparam logic [1:0] ICON_ROPE  = 2'b01;
  localparam logic [1:0] ICON_KNOT  = 2'b10;
  localparam logic [1:0] ICON_FLASH = 2'b11;

  // Win states are the two encodings with the MSB set.
  function automatic logic is_win(input state_e st);
    return st[1];
  endfunction

endpackage : rope_pkg
`default_nettype wire

// File: rtl/rope_pull_counter.sv
`default_nettype none
// ============================================================================
// Module : rope_pull_counter
// Purpose: Saturating pull-pulse counter with synchronous clear. A pulse that
//          arrives in the same cycle as the clear is kept, so it counts toward
//          the next accumulation window instead of being lost.
// Ports  : clk_i  - clock
//          rst_i  - asynchronous active-high reset
//          clr_i  - synchronous clear (start of a new window)
//          inc_i  - one-cycle increment request
//          cnt_o  - current count, saturates at 2^CNT_W-1
// Rev    : 1.0  initial release
// ============================================================================
module rope_pull_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : rope_pull_counter
`default_nettype wire

// File: rtl/rope_engine.sv
`default_nettype none
// ============================================================================
// Module : rope_engine
// Purpose: Tug-of-war rope engine. Accumulates per-player pull pulses over a
//          frame, applies one clamped move per frame tick, runs the
//          IDLE/PLAY/WIN state machine and produces a registered per-pixel
//          icon code for the colorizer.
// Ports  : clk_i           - pixel clock
//          reset_i         - asynchronous active-high reset
//          frame_tick_i    - one-cycle pulse at start of vertical blank
//          start_i         - one-cycle start / restart pulse
//          pull_up_i       - debounced pull toward the top
//          pull_dn_i       - debounced pull toward the bottom
//          pixel_row_i     - current scan row
//          pixel_column_i  - current scan column
//          rope_loc_o      - current rope row
//          state_o         - game state (IDLE/PLAY/WIN_TOP/WIN_BOT)
//          win_top_o       - high while in WIN_TOP
//          win_bot_o       - high while in WIN_BOT
//          icon_o          - 00 bg, 01 rope, 10 knot, 11 flash (1-cycle latency)
// Rev    : 1.0  initial parametrised release
// ============================================================================
module rope_engine
  import rope_pkg::*;
#(
  parameter int ROPE_WIDTH   = 10,
  parameter int ROW_MIN      = 40,
  parameter int ROW_MAX      = 440,
  parameter int START_LOC    = 240,
  parameter int STEP         = 4,
  parameter int CNT_W        = 4,
  parameter int KNOT_COL     = 320,
  parameter int KNOT_HALF    = 4,
  parameter int FLASH_FRAMES = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             frame_tick_i,
  input  logic             start_i,
  input  logic             pull_up_i,
  input  logic             pull_dn_i,
  input  logic [POS_W-1:0] pixel_row_i,
  input  logic [POS_W-1:0] pixel_column_i,
  output logic [POS_W-1:0] rope_loc_o,
  output logic [1:0]       state_o,
  output logic             win_top_o,
  output logic             win_bot_o,
  output logic [1:0]       icon_o
);

  localparam int FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [POS_W-1:0]          START_P   = POS_W'(START_LOC);
  localparam logic [POS_W-1:0]          ROW_MIN_P = POS_W'(ROW_MIN);
  localparam logic [POS_W-1:0]          ROW_MAX_P = POS_W'(ROW_MAX);
  localparam logic signed [ARITH_W-1:0] ROW_MIN_S = ARITH_W'(ROW_MIN);
  localparam logic signed [ARITH_W-1:0] ROW_MAX_S = ARITH_W'(ROW_MAX);
  localparam logic signed [ARITH_W-1:0] STEP_S    = ARITH_W'(STEP);
  localparam logic signed [ARITH_W-1:0] HALF_S    = ARITH_W'(ROPE_WIDTH / 2);
  localparam logic signed [ARITH_W-1:0] SCR_MAX_S = ARITH_W'((1 << POS_W) - 1);
  localparam logic signed [ARITH_W-1:0] KNOT_LO_S = ARITH_W'(KNOT_COL - KNOT_HALF);
  localparam logic signed [ARITH_W-1:0] KNOT_HI_S = ARITH_W'(KNOT_COL + KNOT_HALF);
  localparam logic [FLASH_W-1:0]        FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_e             state_q;
  logic [POS_W-1:0]   rope_loc_q;
  logic               win_top_q;
  logic               win_bot_q;
  logic               flash_q;
  logic [FLASH_W-1:0] flash_cnt_q;
  logic [1:0]         icon_q;
  logic [1:0]         icon_d;

  // --------------------------------------------------------------------------
  // Pull counters. Pulses only count during PLAY and never in a start cycle;
  // outside PLAY the counters are held clear.
  // --------------------------------------------------------------------------
  logic             in_play_d;
  logic             cnt_clr_d;
  logic             up_inc_d;
  logic             dn_inc_d;
  logic [CNT_W-1:0] up_cnt;
  logic [CNT_W-1:0] dn_cnt;

  assign in_play_d = (state_q == ST_PLAY);
  assign cnt_clr_d = start_i | frame_tick_i | ~in_play_d;
  assign up_inc_d  = pull_up_i & in_play_d & ~start_i;
  assign dn_inc_d  = pull_dn_i & in_play_d & ~start_i;

  rope_pull_counter #(.CNT_W(CNT_W)) u_up_cnt (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .clr_i (cnt_clr_d),
    .inc_i (up_inc_d),
    .cnt_o (up_cnt)
  );

  rope_pull_counter #(.CNT_W(CNT_W)) u_dn_cnt (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .clr_i (cnt_clr_d),
    .inc_i (dn_inc_d),
    .cnt_o (dn_cnt)
  );

  // --------------------------------------------------------------------------
  // Move arithmetic: positive net pulls the rope upward (smaller row).
  // --------------------------------------------------------------------------
  logic signed [CNT_W:0]     net_d;
  logic signed [ARITH_W-1:0] net_ext_d;
  logic signed [ARITH_W-1:0] move_d;
  logic signed [ARITH_W-1:0] rope_ext_d;
  logic signed [ARITH_W-1:0] next_raw_d;
  logic                      hit_top_d;
  logic                      hit_bot_d;
  logic [POS_W-1:0]          next_loc_d;

  assign net_d      = $signed({1'b0, up_cnt}) - $signed({1'b0, dn_cnt});
  assign net_ext_d  = $signed({{(ARITH_W-CNT_W-1){net_d[CNT_W]}}, net_d});
  assign move_d     = net_ext_d * STEP_S;
  assign rope_ext_d = $signed({{(ARITH_W-POS_W){1'b0}}, rope_loc_q});
  assign next_raw_d = rope_ext_d - move_d;
  assign hit_top_d  = (next_raw_d <= ROW_MIN_S);
  assign hit_bot_d  = (next_raw_d >= ROW_MAX_S);
  assign next_loc_d = hit_top_d ? ROW_MIN_P :
                      hit_bot_d ? ROW_MAX_P :
                                  next_raw_d[POS_W-1:0];

  // --------------------------------------------------------------------------
  // Game FSM. start has priority over everything, including a coincident
  // frame_tick, so a restart never applies a stale move.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      rope_loc_q  <= START_P;
      win_top_q   <= 1'b0;
      win_bot_q   <= 1'b0;
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else if (start_i) begin
      state_q     <= ST_PLAY;
      rope_loc_q  <= START_P;
      win_top_q   <= 1'b0;
      win_bot_q   <= 1'b0;
      flash_q     <= 1'b0;
      flash_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (frame_tick_i) begin
            rope_loc_q <= next_loc_d;
            if (hit_top_d) begin
              state_q   <= ST_WIN_TOP;
              win_top_q <= 1'b1;
            end else if (hit_bot_d) begin
              state_q   <= ST_WIN_BOT;
              win_bot_q <= 1'b1;
            end
          end
        end
        ST_WIN_TOP, ST_WIN_BOT: begin
          // Rope is frozen; only the flash phase advances.
          if (frame_tick_i) begin
            if (flash_cnt_q == FLASH_LAST) begin
              flash_cnt_q <= '0;
              flash_q     <= ~flash_q;
            end else begin
              flash_cnt_q <= flash_cnt_q + FLASH_W'(1);
            end
          end
        end
        default: begin
          // IDLE: hold until start.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Icon generation against the current rope position. Band edges are clamped
  // to the screen so a rope near row 0 or 1023 does not wrap.
  // --------------------------------------------------------------------------
  logic signed [ARITH_W-1:0] band_lo_raw_d;
  logic signed [ARITH_W-1:0] band_hi_raw_d;
  logic signed [ARITH_W-1:0] band_lo_d;
  logic signed [ARITH_W-1:0] band_hi_d;
  logic signed [ARITH_W-1:0] row_ext_d;
  logic signed [ARITH_W-1:0] col_ext_d;
  logic                      in_band_d;
  logic                      in_knot_d;

  assign band_lo_raw_d = rope_ext_d - HALF_S;
  assign band_hi_raw_d = rope_ext_d + HALF_S;
  assign band_lo_d     = band_lo_raw_d[ARITH_W-1] ? '0 : band_lo_raw_d;
  assign band_hi_d     = (band_hi_raw_d > SCR_MAX_S) ? SCR_MAX_S : band_hi_raw_d;
  assign row_ext_d     = $signed({{(ARITH_W-POS_W){1'b0}}, pixel_row_i});
  assign col_ext_d     = $signed({{(ARITH_W-POS_W){1'b0}}, pixel_column_i});
  assign in_band_d     = (row_ext_d >= band_lo_d) && (row_ext_d <= band_hi_d);
  assign in_knot_d     = (col_ext_d >= KNOT_LO_S) && (col_ext_d <= KNOT_HI_S);

  always_comb begin
    icon_d = ICON_BG;
    if (in_band_d) begin
      if (in_knot_d) begin
        icon_d = ICON_KNOT;
      end else if (is_win(state_q) && flash_q) begin
        icon_d = ICON_FLASH;
      end else begin
        icon_d = ICON_ROPE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      icon_q <= ICON_BG;
    end else begin
      icon_q <= icon_d;
    end
  end

  assign rope_loc_o = rope_loc_q;
  assign state_o    = state_q;
  assign win_top_o  = win_top_q;
  assign win_bot_o  = win_bot_q;
  assign icon_o     = icon_q;

endmodule : rope_engine
`default_nettype wire

// File: tb/tb_rope_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_rope_engine
// Purpose: Self-checking bench for rope_engine: icon table sweeps plus
//          directed multi-cycle game sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rope_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       pull_up;
  logic       pull_dn;
  logic [9:0] pixel_row;
  logic [9:0] pixel_column;
  logic [9:0] rope_loc;
  logic [1:0] state;
  logic       win_top;
  logic       win_bot;
  logic [1:0] icon;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rope_engine dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .frame_tick_i   (frame_tick),
    .start_i        (start),
    .pull_up_i      (pull_up),
    .pull_dn_i      (pull_dn),
    .pixel_row_i    (pixel_row),
    .pixel_column_i (pixel_column),
    .rope_loc_o     (rope_loc),
    .state_o        (state),
    .win_top_o      (win_top),
    .win_bot_o      (win_bot),
    .icon_o         (icon)
  );

  typedef struct {
    logic [9:0] row;
    logic [9:0] col;
    logic [1:0] exp_icon;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // All helpers start and end on a falling edge.
  task automatic pulse_up(input int n);
    for (int i = 0; i < n; i++) begin
      pull_up = 1'b1; @(negedge clk); pull_up = 1'b0; @(negedge clk);
    end
  endtask

  task automatic pulse_dn(input int n);
    for (int i = 0; i < n; i++) begin
      pull_dn = 1'b1; @(negedge clk); pull_dn = 1'b0; @(negedge clk);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic icon_at(input string name, input int r, input int c, input int exp);
    pixel_row = 10'(r); pixel_column = 10'(c);
    @(negedge clk);
    check(name, int'(icon), exp);
  endtask

  task automatic check_core(input string name, input int loc, input int st,
                            input int wt, input int wb);
    check({name, ".rope_loc"}, int'(rope_loc), loc);
    check({name, ".state"},    int'(state),    st);
    check({name, ".win_top"},  int'(win_top),  wt);
    check({name, ".win_bot"},  int'(win_bot),  wb);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
    pull_up = 1'b0; pull_dn = 1'b0; pixel_row = '0; pixel_column = '0;

    // IDLE icon table at rope row 240: band rows 235..245, knot cols 316..324.
    for (int r = 230; r <= 250; r++)
      vecs.push_back('{10'(r), 10'd100, (r >= 235 && r <= 245) ? 2'b01 : 2'b00});
    vecs.push_back('{10'd240, 10'd315, 2'b01});
    vecs.push_back('{10'd240, 10'd316, 2'b10});
    vecs.push_back('{10'd235, 10'd320, 2'b10});
    vecs.push_back('{10'd245, 10'd324, 2'b10});
    vecs.push_back('{10'd240, 10'd325, 2'b01});
    vecs.push_back('{10'd234, 10'd320, 2'b00});
    vecs.push_back('{10'd246, 10'd318, 2'b00});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_core("reset", 240, 0, 0, 0);
    check("reset.icon", int'(icon), 0);

    foreach (vecs[i]) begin
      pixel_row = vecs[i].row; pixel_column = vecs[i].col;
      @(negedge clk);
      check($sformatf("idle_icon[%0d]", i), int'(icon), int'(vecs[i].exp_icon));
    end
    check("idle.state", int'(state), 0);

    // Frame tick in IDLE does nothing
    pulse_up(2); tick();
    check_core("idle_tick", 240, 0, 0, 0);

    // Basic move: 3 up, 1 dn -> net 2 -> 240 - 8
    do_start();
    check("start.state", int'(state), 1);
    pulse_up(3); pulse_dn(1); tick();
    check_core("move1", 232, 1, 0, 0);
    tick();
    check("move_empty", int'(rope_loc), 232);

    // Restart in PLAY, then saturating down counter: 20 pulses count as 15
    do_start();
    check_core("restart_play", 240, 1, 0, 0);
    pulse_dn(20); tick();
    check_core("sat_dn", 300, 1, 0, 0);

    // Walk rope to 44: restart, 3 frames of saturated up (-60 each), then 4 up
    do_start();
    for (int f = 0; f < 3; f++) begin
      pulse_up(18); tick();
    end
    check("walk_60", int'(rope_loc), 60);
    pulse_up(4); tick();
    check_core("at44", 44, 1, 0, 0);

    // 2 up -> 36, clamps to 40, top win
    pulse_up(2); tick();
    check_core("win_top", 40, 2, 1, 0);
    pulse_up(3); pulse_dn(1); tick();   // flash tick 1, pulls ignored
    check_core("win_frozen", 40, 2, 1, 0);

    // Flash: toggles after 16 win-state ticks
    repeat (14) tick();                 // 15 ticks in win
    icon_at("flash0.band", 40, 100, 1);
    icon_at("flash0.edge", 35, 100, 1);
    tick();                             // 16th -> flash on
    icon_at("flash1.band", 40, 100, 3);
    icon_at("flash1.edge", 45, 100, 3);
    icon_at("flash1.knot", 40, 320, 2);
    icon_at("flash1.knot_hi", 42, 324, 2);
    icon_at("flash1.out", 46, 100, 0);
    repeat (15) tick();
    icon_at("flash1.hold", 40, 100, 3);
    tick();                             // 32nd -> flash off
    icon_at("flash2.band", 40, 100, 1);

    // start from win, then start + frame_tick with 5 pending pulls
    do_start();
    check_core("win_restart", 240, 1, 0, 0);
    icon_at("restart.flash_clr", 240, 100, 1);
    tick();                             // advance nothing, keep flash clear
    pulse_up(5);
    start = 1'b1; frame_tick = 1'b1; @(negedge clk);
    start = 1'b0; frame_tick = 1'b0;
    check_core("start_tick", 240, 1, 0, 0);
    tick();
    check("start_tick.cnt_clr", int'(rope_loc), 240);

    // Pull coincident with frame_tick counts toward the next frame
    pulse_up(1);
    pull_up = 1'b1; frame_tick = 1'b1; @(negedge clk);
    pull_up = 1'b0; frame_tick = 1'b0;
    check("coincident.cur", int'(rope_loc), 236);
    tick();
    check("coincident.next", int'(rope_loc), 232);

    // up and dn in the same cycle both count
    pull_up = 1'b1; pull_dn = 1'b1; @(negedge clk);
    pull_up = 1'b0; pull_dn = 1'b0; @(negedge clk);
    pulse_up(1); tick();
    check("both_pulls", int'(rope_loc), 228);

    // Bottom win on exact boundary: 240 -> 300 -> 360 -> 420 -> 440
    do_start();
    for (int f = 0; f < 3; f++) begin
      pulse_dn(16); tick();
    end
    check("walk_420", int'(rope_loc), 420);
    pulse_dn(5); tick();
    check_core("win_bot", 440, 3, 0, 1);

    // Reset mid-frame with pending pulls
    do_start();
    pulse_dn(2); tick();                // rope 248
    check("pre_reset", int'(rope_loc), 248);
    pixel_row = 10'd248; pixel_column = 10'd100;
    pulse_up(3);
    check("pre_reset.icon", int'(icon), 1);
    #2 reset = 1'b1;
    #1;
    check_core("async_reset", 240, 0, 0, 0);
    check("async_reset.icon", int'(icon), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_up(2); tick();
    check_core("post_reset_tick", 240, 0, 0, 0);
    do_start();
    tick();
    check_core("post_reset_start", 240, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_rope_engine
`default_nettype wire
